// File: rtl/time_update_scheduler_if.sv
// Command handshake between the time-update scheduler and the counter bank.
interface time_update_scheduler_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_field;
    logic       cmd_dir;

    modport master (output cmd_valid, output cmd_field, output cmd_dir, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_field, input cmd_dir, output cmd_ready);
endinterface

// File: rtl/time_update_scheduler.sv
// Time update scheduler: merges 1 Hz ticks (run mode) and button
// press/auto-repeat adjust requests (edit mode) into one valid/ready
// command stream towards the clock counter bank.
module time_update_scheduler #(
    parameter int HOLD_CYC   = 500,
    parameter int REPEAT_CYC = 100
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_tick_1hz,
    input  logic                           i_edit_mode,
    input  logic [2:0]                     i_field_sel,
    input  logic                           i_up,
    input  logic                           i_down,
    output logic                           o_tick_ovf,
    time_update_scheduler_if.master        cmd
);

    localparam int MAX_CYC = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC);
    localparam logic [CW-1:0] REP_LD  = CW'(REPEAT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_HOLD_WAIT, S_REPEAT} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_up_q, r_dn_q;
    logic          r_adj_pend;
    logic [2:0]    r_adj_field;
    logic          r_adj_dir;
    logic [1:0]    r_tick_pend;
    logic          r_ovf;
    logic          r_valid;
    logic [2:0]    r_field;
    logic          r_dir;
    logic          r_src_adj;

    logic       w_rise_up, w_rise_dn, w_start, w_held, w_abort, w_fire;
    logic       w_adj_set, w_adj_clr, w_acc, w_acc_tick, w_acc_adj;
    logic       w_tick_in, w_tick_avail, w_adj_avail;
    logic [2:0] w_adj_field_nxt;
    logic       w_adj_dir_nxt;

    assign w_rise_up = i_up & ~r_up_q;
    assign w_rise_dn = i_down & ~r_dn_q;

    // A fresh press of exactly one button on a valid field starts an adjust.
    assign w_start = (r_state == S_IDLE) & i_edit_mode & (i_field_sel <= 3'd5)
                   & (w_rise_up ^ w_rise_dn);
    assign w_held  = r_adj_dir ? i_up : i_down;
    assign w_abort = (r_state != S_IDLE)
                   & (~i_edit_mode | (i_field_sel != r_adj_field) | ~w_held | (i_up & i_down));
    // Counter reaching zero on this edge means a hold/repeat request is due.
    assign w_fire  = (r_state != S_IDLE) & ~w_abort & (r_cnt <= CW'(1));

    assign w_adj_set = w_start | w_fire;
    // Leaving edit mode or moving to another field cancels a queued adjust;
    // a plain release leaves it queued.
    assign w_adj_clr = ~i_edit_mode | ((r_state != S_IDLE) & (i_field_sel != r_adj_field));

    assign w_acc      = r_valid & cmd.cmd_ready;
    assign w_acc_tick = w_acc & ~r_src_adj;
    assign w_acc_adj  = w_acc & r_src_adj;

    assign w_tick_in    = i_tick_1hz & ~i_edit_mode;
    assign w_tick_avail = ~i_edit_mode & ((r_tick_pend != 2'd0) | w_tick_in);
    assign w_adj_avail  = i_edit_mode & ((r_adj_pend & ~w_adj_clr) | w_adj_set);

    assign w_adj_field_nxt = w_start ? i_field_sel : r_adj_field;
    assign w_adj_dir_nxt   = w_start ? w_rise_up   : r_adj_dir;

    // Button history; resets as "pressed" so levels held through reset are not edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_up_q <= 1'b1;
            r_dn_q <= 1'b1;
        end else begin
            r_up_q <= i_up;
            r_dn_q <= i_down;
        end
    end

    // Adjust FSM: press -> hold delay -> periodic repeat, plus the one-deep adjust queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_adj_pend  <= 1'b0;
            r_adj_field <= 3'd0;
            r_adj_dir   <= 1'b0;
        end else begin
            if (w_adj_set)
                r_adj_pend <= 1'b1;
            else if (w_adj_clr | w_acc_adj)
                r_adj_pend <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state     <= S_HOLD_WAIT;
                        r_cnt       <= HOLD_LD;
                        r_adj_field <= i_field_sel;
                        r_adj_dir   <= w_rise_up;
                    end
                end
                S_HOLD_WAIT, S_REPEAT: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (w_fire) begin
                        r_state <= S_REPEAT;
                        r_cnt   <= REP_LD;
                    end else begin
                        r_cnt   <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Pending tick counter, saturating at 3 with a drop pulse; flushed in edit mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_pend <= 2'd0;
            r_ovf       <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            if (i_edit_mode) begin
                r_tick_pend <= 2'd0;
            end else begin
                case ({w_tick_in, w_acc_tick})
                    2'b10: begin
                        if (r_tick_pend == 2'd3)
                            r_ovf <= 1'b1;
                        else
                            r_tick_pend <= r_tick_pend + 2'd1;
                    end
                    2'b01: begin
                        if (r_tick_pend != 2'd0)
                            r_tick_pend <= r_tick_pend - 2'd1;
                    end
                    default: r_tick_pend <= r_tick_pend;
                endcase
            end
        end
    end

    // Command register: hold offer until accepted; ticks beat adjusts when idle;
    // an adjust offer is withdrawn when edit mode ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_field   <= 3'd0;
            r_dir     <= 1'b0;
            r_src_adj <= 1'b0;
        end else if (r_valid) begin
            if (w_acc || (r_src_adj && !i_edit_mode))
                r_valid <= 1'b0;
        end else if (w_tick_avail) begin
            r_valid   <= 1'b1;
            r_field   <= 3'd0;
            r_dir     <= 1'b1;
            r_src_adj <= 1'b0;
        end else if (w_adj_avail) begin
            r_valid   <= 1'b1;
            r_field   <= w_adj_field_nxt;
            r_dir     <= w_adj_dir_nxt;
            r_src_adj <= 1'b1;
        end
    end

    assign cmd.cmd_valid = r_valid;
    assign cmd.cmd_field = r_field;
    assign cmd.cmd_dir   = r_dir;
    assign o_tick_ovf    = r_ovf;

endmodule

// File: tb/tb_time_update_scheduler.sv
// Directed bench for time_update_scheduler with HOLD_CYC=4, REPEAT_CYC=2.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_time_update_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       edit = 1'b0;
    logic [2:0] fsel = 3'd0;
    logic       up = 1'b0;
    logic       dn = 1'b0;
    logic       ovf;
    int         n_checks = 0;
    int         n_fail = 0;

    time_update_scheduler_if u_if ();

    time_update_scheduler #(.HOLD_CYC(4), .REPEAT_CYC(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_tick_1hz (tick),
        .i_edit_mode(edit),
        .i_field_sel(fsel),
        .i_up       (up),
        .i_down     (dn),
        .o_tick_ovf (ovf),
        .cmd        (u_if)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        u_if.cmd_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({u_if.cmd_valid, u_if.cmd_field, u_if.cmd_dir, ovf} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b exp 000000",
                     {u_if.cmd_valid, u_if.cmd_field, u_if.cmd_dir, ovf});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tick_single();
        u_if.cmd_ready = 1'b1;
        edit = 1'b0;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        n_checks++;
        if ({u_if.cmd_valid, u_if.cmd_field, u_if.cmd_dir} !== 5'b1_000_1) begin
            n_fail++;
            $display("FAIL tick_single_cmd got %b exp 10001",
                     {u_if.cmd_valid, u_if.cmd_field, u_if.cmd_dir});
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (u_if.cmd_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL tick_single_after cyc %0d got %b exp 0", k, u_if.cmd_valid);
            end
        end
    endtask

    task automatic test_tick_overflow();
        int acc;
        u_if.cmd_ready = 1'b0;
        edit = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk); tick = 1'b1;
            @(negedge clk); tick = 1'b0;
            n_checks++;
            if (ovf !== (i >= 4)) begin
                n_fail++;
                $display("FAIL tick_ovf_pulse tick %0d got %b exp %b", i, ovf, (i >= 4));
            end
            @(negedge clk);
            n_checks++;
            if (ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL tick_ovf_width tick %0d got %b exp 0", i, ovf);
            end
        end
        n_checks++;
        if ({u_if.cmd_valid, u_if.cmd_field, u_if.cmd_dir} !== 5'b1_000_1) begin
            n_fail++;
            $display("FAIL tick_stalled_cmd got %b exp 10001",
                     {u_if.cmd_valid, u_if.cmd_field, u_if.cmd_dir});
        end
        u_if.cmd_ready = 1'b1;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            if (u_if.cmd_valid === 1'b1) acc++;
            @(negedge clk);
        end
        n_checks++;
        if (acc != 3) begin
            n_fail++;
            $display("FAIL tick_drain_count got %0d exp 3", acc);
        end
    endtask

    task automatic test_hold_repeat();
        logic exp_v;
        int   acc;
        u_if.cmd_ready = 1'b1;
        edit = 1'b1;
        fsel = 3'd2;
        repeat (2) @(negedge clk);
        up = 1'b1;
        acc = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 10) up = 1'b0;
            exp_v = (k == 1) || (k == 5) || (k == 7) || (k == 9);
            n_checks++;
            if (u_if.cmd_valid !== exp_v) begin
                n_fail++;
                $display("FAIL hold_repeat_valid cyc %0d got %b exp %b", k, u_if.cmd_valid, exp_v);
            end
            if (u_if.cmd_valid === 1'b1) begin
                acc++;
                n_checks++;
                if ({u_if.cmd_field, u_if.cmd_dir} !== 4'b010_1) begin
                    n_fail++;
                    $display("FAIL hold_repeat_cmd cyc %0d got %b exp 0101", k,
                             {u_if.cmd_field, u_if.cmd_dir});
                end
            end
        end
        n_checks++;
        if (acc != 4) begin
            n_fail++;
            $display("FAIL hold_repeat_count got %0d exp 4", acc);
        end
    endtask

    task automatic test_stall_coalesce();
        int acc;
        u_if.cmd_ready = 1'b0;
        edit = 1'b1;
        fsel = 3'd3;
        @(negedge clk);
        dn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_checks++;
            if ({u_if.cmd_valid, u_if.cmd_field, u_if.cmd_dir} !== 5'b1_011_0) begin
                n_fail++;
                $display("FAIL stall_hold cyc %0d got %b exp 10110", k,
                         {u_if.cmd_valid, u_if.cmd_field, u_if.cmd_dir});
            end
        end
        dn = 1'b0;
        @(negedge clk);
        u_if.cmd_ready = 1'b1;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            if (u_if.cmd_valid === 1'b1) acc++;
            @(negedge clk);
        end
        n_checks++;
        if (acc != 1) begin
            n_fail++;
            $display("FAIL stall_accept_count got %0d exp 1", acc);
        end
    endtask

    task automatic test_ignored_presses();
        int seen;
        u_if.cmd_ready = 1'b1;
        edit = 1'b1;
        fsel = 3'd1;
        @(negedge clk);
        up = 1'b1; dn = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (u_if.cmd_valid === 1'b1) seen++;
        end
        up = 1'b0; dn = 1'b0;
        repeat (2) @(negedge clk);
        fsel = 3'd6;
        up = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (u_if.cmd_valid === 1'b1) seen++;
        end
        up = 1'b0;
        tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (u_if.cmd_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL ignored_presses valid_cycles got %0d exp 0", seen);
        end
    endtask

    task automatic test_withdraw();
        int seen;
        u_if.cmd_ready = 1'b0;
        edit = 1'b1;
        fsel = 3'd4;
        @(negedge clk);
        up = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({u_if.cmd_valid, u_if.cmd_field, u_if.cmd_dir} !== 5'b1_100_1) begin
            n_fail++;
            $display("FAIL withdraw_offer got %b exp 11001",
                     {u_if.cmd_valid, u_if.cmd_field, u_if.cmd_dir});
        end
        edit = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (u_if.cmd_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL withdraw_after valid_cycles got %0d exp 0", seen);
        end
        up = 1'b0;
        u_if.cmd_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_transfer();
        int seen;
        u_if.cmd_ready = 1'b0;
        edit = 1'b0;
        repeat (2) begin
            @(negedge clk); tick = 1'b1;
            @(negedge clk); tick = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (u_if.cmd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre valid got %b exp 1", u_if.cmd_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({u_if.cmd_valid, u_if.cmd_field, u_if.cmd_dir, ovf} !== 6'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async got %b exp 000000",
                     {u_if.cmd_valid, u_if.cmd_field, u_if.cmd_dir, ovf});
        end
        @(negedge clk);
        rst = 1'b0;
        u_if.cmd_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (u_if.cmd_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rst_mid_after valid_cycles got %0d exp 0", seen);
        end
        tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        n_checks++;
        if ({u_if.cmd_valid, u_if.cmd_field, u_if.cmd_dir} !== 5'b1_000_1) begin
            n_fail++;
            $display("FAIL rst_mid_newtick got %b exp 10001",
                     {u_if.cmd_valid, u_if.cmd_field, u_if.cmd_dir});
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_held_level();
        int seen;
        u_if.cmd_ready = 1'b1;
        edit = 1'b1;
        fsel = 3'd1;
        up = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (u_if.cmd_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rst_level_no_edge valid_cycles got %0d exp 0", seen);
        end
        up = 1'b0;
        @(negedge clk);
        up = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({u_if.cmd_valid, u_if.cmd_field, u_if.cmd_dir} !== 5'b1_001_1) begin
            n_fail++;
            $display("FAIL rst_level_new_edge got %b exp 10011",
                     {u_if.cmd_valid, u_if.cmd_field, u_if.cmd_dir});
        end
        up = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        u_if.cmd_ready = 1'b1;
        test_reset();
        test_tick_single();
        test_tick_overflow();
        test_hold_repeat();
        test_stall_coalesce();
        test_ignored_presses();
        test_withdraw();
        test_reset_mid_transfer();
        test_reset_held_level();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
